// File: rtl/lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : lock_fsm
// Purpose  : Six-digit combination-lock controller feeding the HEX decoder.
//            One BCD digit is accepted per rising edge of 'enter' and compared
//            against COMBO. The 4-bit state code and last digit go to the decoder.
// Encoding : Sa..Sf = 0..5, Sg (OPEN) = 6, DCa..DCe = 7..11, DCf (CLOSED) = 12,
//            codes 13..15 unused and recover to Sa.
// Config   : define AUTO_RELOCK_EN to return from Sg to Sa after RELOCK_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module lock_fsm #(
  parameter logic [23:0] COMBO = 24'h135792
`ifdef AUTO_RELOCK_EN
  ,
  parameter int unsigned RELOCK_CYCLES = 50_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic [3:0] digit,
  output logic [3:0] state,
  output logic [3:0] digit_q,
  output logic       is_open,
  output logic       closed
);

  typedef enum logic [3:0] {
    SA  = 4'h0, SB  = 4'h1, SC  = 4'h2, SD  = 4'h3, SE  = 4'h4, SF = 4'h5,
    SG  = 4'h6,
    DCA = 4'h7, DCB = 4'h8, DCC = 4'h9, DCD = 4'hA, DCE = 4'hB, DCF = 4'hC
  } state_t;

  logic [3:0] r_state;
  logic [3:0] r_digit_q;
  logic       r_is_open;
  logic       r_closed;
  logic       r_e1;
  logic       r_e2;
  logic       r_e3;
  logic [2:0] r_arm;

  logic [3:0] w_next;
  logic [3:0] w_digit_next;
  logic [3:0] w_exp;
  logic       w_match;
  logic       w_press;
  logic       w_relock;

  // Synchronise 'enter', register it once more for edge detection, and hold
  // off presses until the pipeline has been refilled after reset so that a
  // level held through reset is not mistaken for a new press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e1  <= 1'b0;
      r_e2  <= 1'b0;
      r_e3  <= 1'b0;
      r_arm <= 3'b000;
    end else begin
      r_e1  <= enter;
      r_e2  <= r_e1;
      r_e3  <= r_e2;
      r_arm <= {r_arm[1:0], 1'b1};
    end
  end

  assign w_press = r_e2 & ~r_e3 & r_arm[2];

`ifdef AUTO_RELOCK_EN
  localparam logic [25:0] c_relock_max = 26'(RELOCK_CYCLES - 1);

  logic [25:0] r_relock_cnt;

  // Dwell counter: held at zero outside Sg, so it starts from zero on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_relock_cnt <= 26'd0;
    end else if (r_state != SG) begin
      r_relock_cnt <= 26'd0;
    end else begin
      r_relock_cnt <= r_relock_cnt + 26'd1;
    end
  end

  assign w_relock = (r_state == SG) && (r_relock_cnt == c_relock_max);
`else
  assign w_relock = 1'b0;
`endif

  // Combination nibble expected at the current correct-path position.
  always_comb begin
    w_exp = COMBO[23:20];
    case (r_state)
      SA:      w_exp = COMBO[23:20];
      SB:      w_exp = COMBO[19:16];
      SC:      w_exp = COMBO[15:12];
      SD:      w_exp = COMBO[11:8];
      SE:      w_exp = COMBO[7:4];
      SF:      w_exp = COMBO[3:0];
      default: w_exp = COMBO[23:20];
    endcase
  end

  // An illegal digit never matches, even if COMBO itself holds one.
  assign w_match = (digit <= 4'd9) && (digit == w_exp);

  // Next-state and next-digit logic.
  always_comb begin
    w_next       = r_state;
    w_digit_next = r_digit_q;
    case (r_state)
      SA, SB, SC, SD, SE, SF: begin
        if (w_press) begin
          w_digit_next = digit;
          // Correct path advances by one; a miss jumps to the DC state that
          // has the same number of accepted digits (offset 7 in the encoding).
          w_next = w_match ? (r_state + 4'd1) : (r_state + 4'd7);
        end
      end
      DCA, DCB, DCC, DCD, DCE: begin
        if (w_press) begin
          w_digit_next = digit;
          w_next       = r_state + 4'd1;
        end
      end
      SG: begin
        if (w_relock) begin
          w_next       = SA;
          w_digit_next = 4'h0;
        end
      end
      DCF: begin
        w_next = DCF;
      end
      default: begin
        w_next = SA;
      end
    endcase
  end

  // State, digit and flag registers; flags decode the next state so they
  // change on the same edge as 'state'.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SA;
      r_digit_q <= 4'h0;
      r_is_open <= 1'b0;
      r_closed  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_digit_q <= w_digit_next;
      r_is_open <= (w_next == SG);
      r_closed  <= (w_next == DCF);
    end
  end

  assign state   = r_state;
  assign digit_q = r_digit_q;
  assign is_open = r_is_open;
  assign closed  = r_closed;

endmodule
`default_nettype wire
